// File: rtl/price_fifo_pkg.sv
// Shared constants and width helpers for the price window FIFO.
package price_fifo_pkg;

  localparam int PRICE_W = 16;
  localparam int RSI_N   = 20;

  function automatic int ptr_width(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_mod_ptr.sv
// Modulo-DEPTH pointer: advances on i_inc and wraps DEPTH-1 -> 0 explicitly.
module fifo_mod_ptr
  import price_fifo_pkg::*;
#(
  parameter int DEPTH = RSI_N
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_inc,
  output logic [ptr_width(DEPTH)-1:0] o_ptr
);

  localparam int PW = ptr_width(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [PW-1:0] r_ptr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + 1'b1;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/price_window_fifo.sv
// Price sample FIFO feeding the RSI window engine; full means "window primed".
// Define PRICE_FIFO_FWFT_EN for first-word-fall-through reads (default: registered read).
module price_window_fifo
  import price_fifo_pkg::*;
#(
  parameter int DEPTH    = RSI_N,
  parameter int WIDTH    = PRICE_W,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_wr_en,
  input  logic [WIDTH-1:0]            i_din,
  input  logic                        i_rd_en,
  input  logic                        i_clr_err,
  output logic [WIDTH-1:0]            o_dout,
  output logic                        o_dout_valid,
  output logic                        o_full,
  output logic                        o_empty,
  output logic                        o_almost_full,
  output logic                        o_almost_empty,
  output logic [cnt_width(DEPTH)-1:0] o_level,
  output logic                        o_overflow,
  output logic                        o_underflow
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] FULL_L = CW'(DEPTH);
  localparam logic [CW-1:0] AF_L   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_L   = CW'(AE_LEVEL);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_level;
  logic             r_overflow;
  logic             r_underflow;
  logic [PW-1:0]    w_wr_ptr;
  logic [PW-1:0]    w_rd_ptr;
  logic             w_full;
  logic             w_empty;
  logic             w_rd_ok;
  logic             w_wr_ok;

  assign w_full  = (r_level == FULL_L);
  assign w_empty = (r_level == '0);

  // A read from a full FIFO frees the slot the concurrent write lands in.
  assign w_rd_ok = i_rd_en && !w_empty;
  assign w_wr_ok = i_wr_en && (!w_full || w_rd_ok);

  fifo_mod_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (w_wr_ok),
    .o_ptr (w_wr_ptr)
  );

  fifo_mod_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (w_rd_ok),
    .o_ptr (w_rd_ptr)
  );

  always_ff @(posedge i_clk) begin
    if (w_wr_ok && !i_rst) begin
      r_mem[w_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_level <= '0;
    end else if (w_wr_ok && !w_rd_ok) begin
      r_level <= r_level + 1'b1;
    end else if (w_rd_ok && !w_wr_ok) begin
      r_level <= r_level - 1'b1;
    end
  end

  // Set has priority over clear so an error in the clearing cycle is not lost.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (i_wr_en && !w_wr_ok) begin
        r_overflow <= 1'b1;
      end else if (i_clr_err) begin
        r_overflow <= 1'b0;
      end
      if (i_rd_en && !w_rd_ok) begin
        r_underflow <= 1'b1;
      end else if (i_clr_err) begin
        r_underflow <= 1'b0;
      end
    end
  end

`ifdef PRICE_FIFO_FWFT_EN
  assign o_dout       = r_mem[w_rd_ptr];
  assign o_dout_valid = !w_empty;
`else
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_dout_valid <= w_rd_ok;
      if (w_rd_ok) begin
        r_dout <= r_mem[w_rd_ptr];
      end
    end
  end

  assign o_dout       = r_dout;
  assign o_dout_valid = r_dout_valid;
`endif

  assign o_full         = w_full;
  assign o_empty        = w_empty;
  assign o_almost_full  = (r_level >= AF_L);
  assign o_almost_empty = (r_level <= AE_L);
  assign o_level        = r_level;
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_price_window_fifo.sv
// Directed bench for price_window_fifo with a queue model and output scoreboard.
// Honours PRICE_FIFO_FWFT_EN to match the DUT build.
module tb_price_window_fifo;

  localparam int DEPTH = 20;
  localparam int WIDTH = 16;
  localparam int CW    = 5;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b0;
  logic             i_wr_en = 1'b0;
  logic [WIDTH-1:0] i_din = '0;
  logic             i_rd_en = 1'b0;
  logic             i_clr_err = 1'b0;
  logic [WIDTH-1:0] o_dout;
  logic             o_dout_valid;
  logic             o_full;
  logic             o_empty;
  logic             o_almost_full;
  logic             o_almost_empty;
  logic [CW-1:0]    o_level;
  logic             o_overflow;
  logic             o_underflow;

  price_window_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_wr_en        (i_wr_en),
    .i_din          (i_din),
    .i_rd_en        (i_rd_en),
    .i_clr_err      (i_clr_err),
    .o_dout         (o_dout),
    .o_dout_valid   (o_dout_valid),
    .o_full         (o_full),
    .o_empty        (o_empty),
    .o_almost_full  (o_almost_full),
    .o_almost_empty (o_almost_empty),
    .o_level        (o_level),
    .o_overflow     (o_overflow),
    .o_underflow    (o_underflow)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;
  int mq[$];
  int exp_q[$];
  bit m_ovf = 0;
  bit m_unf = 0;
  bit m_dv  = 0;
  int m_dout = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".level"}, 32'(o_level), 32'(mq.size()));
    chk({tag, ".full"}, 32'(o_full), 32'(mq.size() == DEPTH));
    chk({tag, ".empty"}, 32'(o_empty), 32'(mq.size() == 0));
    chk({tag, ".afull"}, 32'(o_almost_full), 32'(mq.size() >= DEPTH - 2));
    chk({tag, ".aempty"}, 32'(o_almost_empty), 32'(mq.size() <= 2));
    chk({tag, ".ovf"}, 32'(o_overflow), 32'(m_ovf));
    chk({tag, ".unf"}, 32'(o_underflow), 32'(m_unf));
`ifdef PRICE_FIFO_FWFT_EN
    chk({tag, ".dv"}, 32'(o_dout_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) chk({tag, ".dout"}, 32'(o_dout), 32'(mq[0]));
`else
    chk({tag, ".dv"}, 32'(o_dout_valid), 32'(m_dv));
    chk({tag, ".dout"}, 32'(o_dout), 32'(m_dout));
`endif
  endtask

  // One clock of stimulus; the model is advanced with the pre-edge state.
  task automatic cyc(input string tag, input bit wr, input int d, input bit rd, input bit clr);
    bit rok;
    bit wok;
    rok = rd && (mq.size() > 0);
    wok = wr && ((mq.size() < DEPTH) || rok);
    i_wr_en = wr; i_din = WIDTH'(d); i_rd_en = rd; i_clr_err = clr;
    if (rok) exp_q.push_back(mq.pop_front());
    if (wok) mq.push_back(d);
    if (wr && !wok) m_ovf = 1; else if (clr) m_ovf = 0;
    if (rd && !rok) m_unf = 1; else if (clr) m_unf = 0;
    m_dv = rok;
    @(posedge i_clk); #1;
    i_wr_en = 0; i_rd_en = 0; i_clr_err = 0;
`ifdef PRICE_FIFO_FWFT_EN
    if (rok) void'(exp_q.pop_front());
`else
    if (rok) m_dout = exp_q.pop_front();
`endif
    chk_all(tag);
  endtask

  // Reset asserted together with a write to confirm reset priority.
  task automatic do_reset(input string tag);
    i_rst = 1; i_wr_en = 1; i_din = 16'd123; i_rd_en = 1; i_clr_err = 0;
    @(posedge i_clk); #1;
    i_rst = 0; i_wr_en = 0; i_rd_en = 0;
    mq.delete(); exp_q.delete();
    m_ovf = 0; m_unf = 0; m_dv = 0; m_dout = 0;
    chk_all(tag);
  endtask

  initial begin
    i_rst = 1;
    @(posedge i_clk); #1;
    do_reset("reset");
    for (int i = 0; i < 10; i++) cyc("idle", 0, 0, 0, 0);

    for (int i = 0; i < 20; i++) cyc("fill1", 1, 100 + i, 0, 0);
    for (int i = 0; i < 20; i++) cyc("drain1", 0, 0, 1, 0);
    cyc("post_drain1", 0, 0, 0, 0);

    for (int i = 0; i < 20; i++) cyc("fill2", 1, 200 + i, 0, 0);
    cyc("ovf_write", 1, 500, 0, 0);
    cyc("ovf_hold", 0, 0, 0, 0);
    cyc("ovf_clr", 0, 0, 0, 1);

    for (int i = 0; i < 25; i++) cyc("full_rw", 1, 777, 1, 0);
    for (int i = 0; i < 20; i++) cyc("drain2", 0, 0, 1, 0);
    cyc("post_drain2", 0, 0, 0, 0);

    cyc("empty_rw", 1, 42, 1, 0);
    cyc("read42", 0, 0, 1, 0);
    cyc("unf_hold", 0, 0, 0, 0);
    cyc("unf_set_wins", 0, 0, 1, 1);
    cyc("unf_clr", 0, 0, 0, 1);

    for (int i = 0; i < 7; i++) cyc("fill7", 1, 300 + i, 0, 0);
    cyc("ovf_at_full_pre", 0, 0, 0, 0);
    do_reset("mid_reset");
    cyc("after_reset", 0, 0, 0, 0);

    cyc("write9", 1, 9, 0, 0);
    cyc("hold9", 0, 0, 0, 0);
    cyc("read9", 0, 0, 1, 0);
    cyc("final", 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/price_window_fifo.md
Name: price_window_fifo

Overview:
- Parametrised successor to the single-channel price FIFO. Buffers a stream of price samples ahead of the RSI gain/loss accumulators.
- Adds the following over the previous generation:
  - non-power-of-two depth with explicit wrap
  - correct simultaneous read/write accounting
  - occupancy level and almost-full/almost-empty thresholds
  - sticky overflow/underflow error flags
  - registered read with a data-valid strobe
- Sits between the price ingest interface and the RSI window engine. The window engine treats full as "window primed".

Parameters:
- DEPTH, 20, number of entries; any integer >= 2.
- WIDTH, 16, price sample width in bits.
- AF_LEVEL, DEPTH-2, almost_full asserts when level >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when level <= AE_LEVEL.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write request
- din  in  WIDTH  write data
- rd_en  in  1  read request (pop)
- clr_err  in  1  clears overflow/underflow
- dout  out  WIDTH  read data
- dout_valid  out  1  dout updated this cycle
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- almost_full  out  1  level >= AF_LEVEL
- almost_empty  out  1  level <= AE_LEVEL
- level  out  clog2(DEPTH+1)  current occupancy
- overflow  out  1  sticky: write rejected
- underflow  out  1  sticky: read rejected

Behaviour:
- Interface: one clock, clk. Reset is rst, synchronous, active-high.
- Reset values: wr_ptr=0, rd_ptr=0, level=0, dout=0, dout_valid=0, overflow=0, underflow=0. Consequently empty=1, full=0, almost_empty=1, almost_full=0. Storage array is not reset.
- Reset priority: rst beats all other inputs in the same cycle. Reset mid-stream discards contents; the next cycle is empty.
- Status outputs: full, empty, almost_full and almost_empty are combinational from the level register.
- Read acceptance: rd_ok = rd_en && !empty.
- Write acceptance: wr_ok = wr_en && (!full || rd_ok).
  - When full, a simultaneous read frees a slot, so the write is accepted.
- Write path: on wr_ok, mem[wr_ptr] <= din.
- Read path: on rd_ok, dout <= mem[rd_ptr]. dout_valid is 1 the next cycle and 0 otherwise; latency is 1 cycle. dout holds its last value when no read occurs.
- Pointer advance: a pointer advances only on its accept. Wrap is explicit: DEPTH-1 -> 0. Never rely on natural binary rollover.
- Level update:
  - wr_ok only: +1
  - rd_ok only: -1
  - both: unchanged
  - level never exceeds DEPTH and never goes below 0.
- Simultaneous read and write when empty: the read is rejected and sets underflow; the write is accepted; level becomes 1. A newly written word is readable only from the next cycle; there is no same-cycle bypass.
- Error flags:
  - overflow <= 1 on wr_en && !wr_ok.
  - underflow <= 1 on rd_en && !rd_ok.
  - Both are sticky until clr_err=1 or rst.
  - If clr_err and a new error occur in the same cycle, the flag ends at 1 (set wins).
- Rejected operations change neither pointers, level nor memory.

Optional Feature:
- Macro: PRICE_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - dout = mem[rd_ptr] combinationally.
  - dout_valid = !empty.
  - rd_en acts as an acknowledge: it pops the current head; the next head appears the following cycle.
  - Reset value of dout_valid is 0, because the FIFO is empty.
- Undefined: registered 1-cycle-latency read as described in Behaviour.
- All acceptance, level and flag rules are identical in both modes.

Decomposition:
- Package price_fifo_pkg holds:
  - the default WIDTH constant (PRICE_W=16)
  - the default RSI window constant (RSI_N=20)
  - a ptr_width(depth) function returning clog2(depth), minimum 1
  - a cnt_width(depth) function returning clog2(depth+1)
- One sub-module, fifo_mod_ptr: a modulo-DEPTH pointer with increment enable and synchronous reset. It is instantiated twice, for wr_ptr and rd_ptr.

Test Plan:
- Reset then idle: dout=0, level=0, empty=1, almost_empty=1, flags=0, held for 10 cycles.
- Write 20 samples 100..119 -> full=1 after the 20th, level=20, almost_full=1 from level 18. Then read 20 -> dout sequence 100..119, each 1 cycle after rd_en; empty=1 at the end.
- Fill to 20, then wr_en=1 din=500 with rd_en=0 -> overflow=1, level stays 20, contents unchanged. Pulse clr_err -> overflow=0.
- Full FIFO, rd_en=wr_en=1 with din=777 for 25 cycles -> level stays 20. Pointers wrap past index 19 with no corruption; 777 emerges after the 20 originals.
- Empty FIFO, rd_en=wr_en=1 with din=42 -> underflow=1, level=1. Next-cycle read -> dout=42.
- rst asserted mid-stream at level=7 -> next cycle level=0, dout_valid=0, empty=1. Run both with and without PRICE_FIFO_FWFT_EN; under FWFT, first write 9 -> dout=9, dout_valid=1 without any rd_en.
